// File: rtl/ram_sdp_lane_clr_if.sv
// Port bundle for the lane-writable edge-message store: clear control, write port and read port.
interface ram_sdp_lane_clr_if #(
    parameter int LANE_WIDTH = 8,
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 8
);
    localparam int DATA_WIDTH = LANES * LANE_WIDTH;

    logic                  clr_start;
    logic                  clr_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LANES-1:0]      wr_lane_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  err_oob;

    modport master (
        output clr_start, wr_en, wr_addr, wr_lane_en, wr_data, rd_en, rd_addr,
        input  clr_busy, rd_data, rd_valid, err_oob
    );

    modport slave (
        input  clr_start, wr_en, wr_addr, wr_lane_en, wr_data, rd_en, rd_addr,
        output clr_busy, rd_data, rd_valid, err_oob
    );
endinterface

// File: rtl/ram_sdp_lane_clr.sv
// Simple dual-port RAM with per-lane writes, pipelined reads, selectable read-during-write
// behaviour and a one-word-per-cycle clear sequencer that runs after reset or on request.
module ram_sdp_lane_clr #(
    parameter int                   LANE_WIDTH  = 8,
    parameter int                   LANES       = 2,
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int                   RD_LATENCY  = 1,
    parameter int                   RDW_MODE    = 0,
    parameter logic [LANE_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic               clk,
    input logic               reset,
    ram_sdp_lane_clr_if.slave bus
);
    localparam int                    DATA_WIDTH = LANES * LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = {LANES{CLEAR_VALUE}};

    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
        $error("RD_LATENCY must be 1..3");
    end
    if (RAM_DEPTH < 2 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("RAM_DEPTH must be 2..2^ADDR_WIDTH");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  clr_we;
    logic                  port_open;
    logic                  clr_busy;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_en
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) w[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Array is never touched while reset is held, hence the !reset gating on both paths.
    always_comb begin
        clr_busy  = 1'b0;
        clr_we    = 1'b0;
        port_open = 1'b0;
        case (state)
            IDLE:    port_open = !reset;
            CLEAR: begin
                clr_busy = 1'b1;
                clr_we   = !reset;
            end
            default: ;
        endcase
    end

    logic                  wr_go, rd_go, wr_oob, rd_oob;
    logic [LANES-1:0]      wr_lanes;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [LANES-1:0]      m_lanes;
    logic [DATA_WIDTH-1:0] m_data;
    logic [DATA_WIDTH-1:0] old_word, rd_word;

    always_comb begin
        wr_go    = port_open && bus.wr_en;
        rd_go    = port_open && bus.rd_en;
        wr_oob   = {1'b0, bus.wr_addr} >= DEPTH_X;
        rd_oob   = {1'b0, bus.rd_addr} >= DEPTH_X;
        wr_lanes = (wr_go && !wr_oob) ? bus.wr_lane_en : '0;
        m_addr   = clr_we ? cnt : bus.wr_addr;
        m_lanes  = clr_we ? '1 : wr_lanes;
        m_data   = clr_we ? CLEAR_WORD : bus.wr_data;
        old_word = mem[bus.rd_addr];
        if (rd_oob) begin
            rd_word = '0;
        end else if (RDW_MODE == 1 && wr_lanes != '0 && bus.wr_addr == bus.rd_addr) begin
            rd_word = merge_lanes(old_word, bus.wr_data, wr_lanes);
        end else begin
            rd_word = old_word;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (m_lanes[i]) mem[m_addr][i*LANE_WIDTH +: LANE_WIDTH] <= m_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    // Read pipeline: stage 0 captures at acceptance, later stages shift only on valid so the
    // last stage holds the most recent returned word between reads.
    logic [DATA_WIDTH-1:0] data_p [RD_LATENCY];
    logic [RD_LATENCY-1:0] vld_p;
    logic                  err_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p  <= '0;
            err_p0 <= 1'b0;
            for (int s = 0; s < RD_LATENCY; s++) data_p[s] <= '0;
        end else begin
            vld_p[0] <= rd_go;
            if (rd_go) data_p[0] <= rd_word;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
                if (vld_p[s-1]) data_p[s] <= data_p[s-1];
            end
            err_p0 <= (wr_go && wr_oob) || (rd_go && rd_oob);
        end
    end

    assign bus.clr_busy = clr_busy;
    assign bus.rd_data  = data_p[RD_LATENCY-1];
    assign bus.rd_valid = vld_p[RD_LATENCY-1];
    assign bus.err_oob  = err_p0;
endmodule

// File: tb/tb_ram_sdp_lane_clr.sv
// Directed bench driving three configurations in lock-step (default, latency 3 + new-data RDW,
// depth 200) with queued expectations popped by a monitor whenever a read returns.
module tb_ram_sdp_lane_clr;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [1:0]  wr_lane_en = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;

    always #5 clk = ~clk;

    ram_sdp_lane_clr_if bus0 ();
    ram_sdp_lane_clr_if bus1 ();
    ram_sdp_lane_clr_if bus2 ();

    assign bus0.clr_start = clr_start;  assign bus1.clr_start = clr_start;  assign bus2.clr_start = clr_start;
    assign bus0.wr_en = wr_en;          assign bus1.wr_en = wr_en;          assign bus2.wr_en = wr_en;
    assign bus0.wr_addr = wr_addr;      assign bus1.wr_addr = wr_addr;      assign bus2.wr_addr = wr_addr;
    assign bus0.wr_lane_en = wr_lane_en; assign bus1.wr_lane_en = wr_lane_en; assign bus2.wr_lane_en = wr_lane_en;
    assign bus0.wr_data = wr_data;      assign bus1.wr_data = wr_data;      assign bus2.wr_data = wr_data;
    assign bus0.rd_en = rd_en;          assign bus1.rd_en = rd_en;          assign bus2.rd_en = rd_en;
    assign bus0.rd_addr = rd_addr;      assign bus1.rd_addr = rd_addr;      assign bus2.rd_addr = rd_addr;

    ram_sdp_lane_clr dut0 (.clk(clk), .reset(reset), .bus(bus0));
    ram_sdp_lane_clr #(.RD_LATENCY(3), .RDW_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    ram_sdp_lane_clr #(.RAM_DEPTH(200)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [15:0] rdd [3];
    logic        rdv [3];
    logic        err [3];
    logic        busy [3];
    assign rdd[0] = bus0.rd_data;  assign rdd[1] = bus1.rd_data;  assign rdd[2] = bus2.rd_data;
    assign rdv[0] = bus0.rd_valid; assign rdv[1] = bus1.rd_valid; assign rdv[2] = bus2.rd_valid;
    assign err[0] = bus0.err_oob;  assign err[1] = bus1.err_oob;  assign err[2] = bus2.err_oob;
    assign busy[0] = bus0.clr_busy; assign busy[1] = bus1.clr_busy; assign busy[2] = bus2.clr_busy;

    int          cyc = 0;
    int          ncmp = 0;
    int          nfail = 0;
    logic [15:0] dq [3][$];
    int          tq [3][$];
    int          eq [$];
    logic [15:0] last [3];
    bit          hl [3] = '{0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every returned read is checked against the head of its queue, including the cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdv[i]) begin
                ncmp++;
                if (dq[i].size() == 0) begin
                    nfail++;
                    $display("FAIL rd_unexpected dut%0d cyc=%0d: got valid data=%h, required no valid", i, cyc, rdd[i]);
                end else begin
                    logic [15:0] ed;
                    int          et;
                    ed = dq[i].pop_front();
                    et = tq[i].pop_front();
                    if (rdd[i] !== ed || cyc != et) begin
                        nfail++;
                        $display("FAIL rd_data dut%0d: got %h at cyc %0d, required %h at cyc %0d", i, rdd[i], cyc, ed, et);
                    end
                end
                last[i] = rdd[i];
                hl[i]   = 1'b1;
            end else begin
                if (tq[i].size() != 0 && tq[i][0] <= cyc) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL rd_missing dut%0d cyc=%0d: got no valid, required data=%h", i, cyc, dq[i][0]);
                    void'(dq[i].pop_front());
                    void'(tq[i].pop_front());
                end
                if (hl[i]) begin
                    ncmp++;
                    if (rdd[i] !== last[i]) begin
                        nfail++;
                        $display("FAIL rd_hold dut%0d cyc=%0d: got %h, required %h", i, cyc, rdd[i], last[i]);
                    end
                end
            end
            begin
                bit exp_err;
                exp_err = (i == 2) && (eq.size() != 0) && (eq[0] == cyc);
                if (exp_err) void'(eq.pop_front());
                if (err[i] || exp_err) begin
                    ncmp++;
                    if (err[i] !== exp_err) begin
                        nfail++;
                        $display("FAIL err_oob dut%0d cyc=%0d: got %b, required %b", i, cyc, err[i], exp_err);
                    end
                end
            end
            if (reset) hl[i] = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic push_err(input int t);
        if (eq.size() == 0 || eq[$] != t) eq.push_back(t);
    endtask

    task automatic set_rd(input logic [7:0] a, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        rd_en   = 1'b1;
        rd_addr = a;
        dq[0].push_back(e0); tq[0].push_back(cyc + 1);
        dq[1].push_back(e1); tq[1].push_back(cyc + 3);
        dq[2].push_back(e2); tq[2].push_back(cyc + 1);
        if (a >= 8'd200) push_err(cyc + 1);
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] le);
        wr_en      = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        wr_lane_en = le;
        if (a >= 8'd200) push_err(cyc + 1);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        ncmp++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Counts busy cycles over a fixed window; with poke, drops a write, read and clr_start mid-clear.
    task automatic count_busy(input int e0, input int e1, input int e2, input bit poke);
        int c [3] = '{0, 0, 0};
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) c[j] += int'(busy[j]);
            if (poke && i == 50) begin
                wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hFFFF; wr_lane_en = 2'b11;
                rd_en = 1'b1; rd_addr = 8'd5; clr_start = 1'b1;
            end else if (poke && i == 51) begin
                wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
            end
        end
        check("busy_cycles_dut0", 16'(c[0]), 16'(e0));
        check("busy_cycles_dut1", 16'(c[1]), 16'(e1));
        check("busy_cycles_dut2", 16'(c[2]), 16'(e2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_rd_valid_dut%0d", i), 16'(rdv[i]), 16'h0);
            check($sformatf("reset_rd_data_dut%0d", i), rdd[i], 16'h0000);
            check($sformatf("reset_err_dut%0d", i), 16'(err[i]), 16'h0);
            check($sformatf("reset_busy_dut%0d", i), 16'(busy[i]), 16'h1);
        end
        reset = 1'b0;
        count_busy(256, 256, 200, 1'b0);

        for (int a = 0; a < 256; a++) begin
            set_rd(8'(a), 16'h0000, 16'h0000, 16'h0000);
            tick();
        end

        set_wr(8'd5, 16'hA1B2, 2'b11); tick();
        set_wr(8'd5, 16'hFFC3, 2'b01); tick();
        set_rd(8'd5, 16'hA1C3, 16'hA1C3, 16'hA1C3); tick();

        for (int k = 0; k < 4; k++) begin
            set_wr(8'(k), 16'(16'h0011 * k), 2'b11); tick();
        end
        for (int k = 0; k < 4; k++) begin
            set_rd(8'(k), 16'(16'h0011 * k), 16'(16'h0011 * k), 16'(16'h0011 * k)); tick();
        end

        set_wr(8'd7, 16'h1234, 2'b11); tick();
        set_wr(8'd7, 16'hBEEF, 2'b10);
        set_rd(8'd7, 16'h1234, 16'hBE34, 16'h1234); tick();
        set_rd(8'd7, 16'hBE34, 16'hBE34, 16'hBE34); tick();
        set_wr(8'd7, 16'h0000, 2'b00); tick();
        set_rd(8'd7, 16'hBE34, 16'hBE34, 16'hBE34); tick();
        set_wr(8'd8, 16'h7777, 2'b11);
        set_rd(8'd9, 16'h0000, 16'h0000, 16'h0000); tick();
        set_rd(8'd8, 16'h7777, 16'h7777, 16'h7777); tick();

        set_wr(8'd210, 16'h5555, 2'b11); tick();
        set_rd(8'd210, 16'h5555, 16'h5555, 16'h0000); tick();
        set_rd(8'd10, 16'h0000, 16'h0000, 16'h0000); tick();
        repeat (6) tick();

        clr_start = 1'b1; tick();
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                wr_en = 1'b1; wr_addr = 8'd7; wr_data = 16'hAAAA; wr_lane_en = 2'b11;
            end
            tick();
        end
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        count_busy(256, 256, 200, 1'b1);

        set_rd(8'd5, 16'h0000, 16'h0000, 16'h0000); tick();
        set_rd(8'd7, 16'h0000, 16'h0000, 16'h0000); tick();
        set_rd(8'd210, 16'h0000, 16'h0000, 16'h0000); tick();
        repeat (6) tick();

        check("queues_drained", 16'(dq[0].size() + dq[1].size() + dq[2].size() + eq.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end
endmodule
